// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the asynchronous FIFO: write request, pointers and
// status flags. almost_full is present only when FIFO_WALMOST_FULL_EN
// is defined.
interface fifo_wptr_full_if #(
    parameter int unsigned PTR_W = 6,
    parameter int unsigned CNT_W = 7
);
    logic             w_en;
    logic [CNT_W-1:0] r_gptr;
    logic [PTR_W-1:0] w_ptr;
    logic             full;
    logic [CNT_W-1:0] w_gptr;
`ifdef FIFO_WALMOST_FULL_EN
    logic             almost_full;

    modport master (
        input  w_en,
        input  r_gptr,
        output w_ptr,
        output full,
        output w_gptr,
        output almost_full
    );

    modport slave (
        output w_en,
        output r_gptr,
        input  w_ptr,
        input  full,
        input  w_gptr,
        input  almost_full
    );
`else
    modport master (
        input  w_en,
        input  r_gptr,
        output w_ptr,
        output full,
        output w_gptr
    );

    modport slave (
        output w_en,
        output r_gptr,
        input  w_ptr,
        input  full,
        input  w_gptr
    );
`endif
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag controller for the asynchronous FIFO.
// The sequence index s walks a mirror-symmetric range BASE..BASE+2*DEPTH-1
// so its Gray code changes one bit per step, wrap included. The read Gray
// pointer is synchronized in and compared against the post-accept count.
// Optional almost_full output: define FIFO_WALMOST_FULL_EN.
module fifo_wptr_full #(
    parameter int unsigned DEPTH       = 45,
    parameter int unsigned ADDR_LO     = 9,
    parameter int unsigned PTR_W       = 6,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = 40
) (
    input  logic              w_clk,
    input  logic              arstn,
    fifo_wptr_full_if.master  bus
);

    localparam int unsigned CYC  = 2 * DEPTH;
    localparam int unsigned BASE = (2 ** (CNT_W - 1)) - DEPTH;

    localparam logic [CNT_W-1:0] S_BASE = CNT_W'(BASE);
    localparam logic [CNT_W-1:0] S_TOP  = CNT_W'(BASE + CYC - 1);
    localparam logic [CNT_W-1:0] G_BASE = S_BASE ^ (S_BASE >> 1);
    localparam logic [PTR_W-1:0] P_LO   = PTR_W'(ADDR_LO);
    localparam logic [PTR_W-1:0] P_HI   = PTR_W'(ADDR_LO + DEPTH - 1);

    // Occupancy arithmetic carries one extra bit so c + CYC - rc never wraps.
    localparam logic [CNT_W:0] O_BASE  = (CNT_W + 1)'(BASE);
    localparam logic [CNT_W:0] O_CYC   = (CNT_W + 1)'(CYC);
    localparam logic [CNT_W:0] O_DEPTH = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W:0] O_AF    = (CNT_W + 1)'(AF_LEVEL);

    logic [CNT_W-1:0] s_q, s_d;
    logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
    logic [CNT_W-1:0] w_gptr_q, w_gptr_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] sync_d [SYNC_STAGES];
    logic             af_d;

    logic             accept;
    logic [CNT_W-1:0] r_bin;
    logic [CNT_W:0]   c_next;
    logic [CNT_W:0]   rc;
    logic [CNT_W:0]   occ_raw;
    logic [CNT_W:0]   occ;

    // Read-pointer synchronizer shift chain.
    always_comb begin
        sync_d[0] = bus.r_gptr;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Pointer advance on accept, then occupancy and flag evaluation.
    always_comb begin
        accept  = bus.w_en && !full_q;
        s_d     = s_q;
        w_ptr_d = w_ptr_q;
        if (accept) begin
            s_d     = (s_q == S_TOP) ? S_BASE : s_q + CNT_W'(1);
            // Address wraps every DEPTH steps, i.e. twice per sequence cycle.
            w_ptr_d = (w_ptr_q == P_HI) ? P_LO : w_ptr_q + PTR_W'(1);
        end
        w_gptr_d = s_d ^ (s_d >> 1);

        r_bin = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            r_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
        end

        c_next  = {1'b0, s_d} - O_BASE;
        rc      = {1'b0, r_bin} - O_BASE;
        occ_raw = c_next + O_CYC - rc;
        occ     = (occ_raw >= O_CYC) ? occ_raw - O_CYC : occ_raw;
        full_d  = (occ == O_DEPTH);
        af_d    = (occ >= O_AF);
    end

    // Write-domain state; synchronizer resets to the read side's reset pointer.
    always_ff @(posedge w_clk or negedge arstn) begin
        if (!arstn) begin
            s_q      <= S_BASE;
            w_ptr_q  <= P_LO;
            w_gptr_q <= G_BASE;
            full_q   <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= G_BASE;
            end
        end else begin
            s_q      <= s_d;
            w_ptr_q  <= w_ptr_d;
            w_gptr_q <= w_gptr_d;
            full_q   <= full_d;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign bus.w_ptr  = w_ptr_q;
    assign bus.w_gptr = w_gptr_q;
    assign bus.full   = full_q;

`ifdef FIFO_WALMOST_FULL_EN
    logic af_q;

    // Almost-full flag, same timing as full.
    always_ff @(posedge w_clk or negedge arstn) begin
        if (!arstn) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign bus.almost_full = af_q;
`else
    logic unused_af;
    assign unused_af = af_d;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: randomized writes and reads
// checked against a count-based reference model.
module tb_fifo_wptr_full;

    localparam int unsigned DEPTH   = 45;
    localparam int unsigned CYC     = 90;
    localparam int unsigned BASE    = 19;
    localparam int unsigned ADDR_LO = 9;
    localparam int unsigned AF      = 40;

    logic w_clk = 1'b0;
    logic arstn = 1'b0;

    fifo_wptr_full_if #(.PTR_W(6), .CNT_W(7)) bus ();

    fifo_wptr_full #(
        .DEPTH(45), .ADDR_LO(9), .PTR_W(6), .CNT_W(7),
        .SYNC_STAGES(2), .AF_LEVEL(40)
    ) dut (
        .w_clk (w_clk),
        .arstn (arstn),
        .bus   (bus)
    );

    always #5 w_clk = ~w_clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: total writes and reads modulo 2*DEPTH.
    int unsigned m_wr, m_rd, d1, d2, acc_cnt;
    bit          m_full, m_af;

    function automatic int unsigned gray(int unsigned v);
        return v ^ (v >> 1);
    endfunction

    task automatic check(string tag, int unsigned got, int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; d1 = 0; d2 = 0; m_full = 0; m_af = 0;
    endtask

    task automatic check_outputs(string tag);
        check({tag, ".w_ptr"}, 32'(bus.w_ptr), ADDR_LO + (m_wr % DEPTH));
        check({tag, ".w_gptr"}, 32'(bus.w_gptr), gray(BASE + m_wr));
        check({tag, ".full"}, 32'(bus.full), 32'(m_full));
`ifdef FIFO_WALMOST_FULL_EN
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(m_af));
`endif
    endtask

    task automatic step(bit we, string tag);
        int unsigned rc_used, occ;
        logic [6:0] prev_g;
        bit acc;
        bus.w_en   = we;
        bus.r_gptr = 7'(gray(BASE + m_rd));
        prev_g     = bus.w_gptr;
        @(posedge w_clk);
        acc = we && !m_full;
        if (acc) begin
            m_wr = (m_wr + 1) % CYC;
            acc_cnt++;
        end
        // Read count reaches the write side two sampling edges late.
        rc_used = d2;
        d2 = d1;
        d1 = m_rd;
        occ    = (m_wr + CYC - rc_used) % CYC;
        m_full = (occ == DEPTH);
        m_af   = (occ >= AF);
        #1;
        check_outputs(tag);
        check({tag, ".gray_hd"}, 32'($countones(bus.w_gptr ^ prev_g)), acc ? 1 : 0);
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        bus.w_en = 1'b0;
        model_reset();
        bus.r_gptr = 7'(gray(BASE));
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        arstn = 1'b1;
    endtask

    initial begin
        int unsigned steps;
        bus.w_en   = 1'b0;
        bus.r_gptr = 7'(gray(BASE));
        acc_cnt    = 0;
        do_reset();

        // Reset values and idle hold.
        check_outputs("reset");
        check("reset.gptr_const", 32'(bus.w_gptr), 32'd26);
        repeat (10) step(1'b0, "idle");

        // Fill with the read side parked at its reset pointer.
        for (int i = 1; i <= 45; i++) begin
            step(1'b1, "fill");
`ifdef FIFO_WALMOST_FULL_EN
            if (i == 40) begin
                check("af40.almost_full", 32'(bus.almost_full), 1);
                check("af40.full", 32'(bus.full), 0);
            end
`endif
        end
        check("fill45.full", 32'(bus.full), 1);
        check("fill45.w_ptr", 32'(bus.w_ptr), 9);

        // Write while full is dropped.
        step(1'b1, "overflow");
        check("overflow.w_ptr", 32'(bus.w_ptr), 9);

        // One read frees a slot after the synchronizer latency.
        m_rd = 1;
        repeat (3) step(1'b0, "drain");
        check("drain.full", 32'(bus.full), 0);
        step(1'b1, "refill");
        check("refill.w_ptr", 32'(bus.w_ptr), 10);

        // Random traffic with a tracking reader, across several wraps.
        acc_cnt = 0;
        steps = 0;
        while (acc_cnt < 200 && steps < 3000) begin
            if (m_rd != m_wr && ($urandom % 2) == 1) m_rd = (m_rd + 1) % CYC;
            step($urandom_range(0, 3) != 0, "rand");
            steps++;
        end
        check("rand.writes_done", acc_cnt >= 200 ? 1 : 0, 1);

        // Asynchronous reset in the middle of a write burst.
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1, "pre_rst");
        #3;
        arstn = 1'b0;
        #1;
        check("arst.w_ptr", 32'(bus.w_ptr), 9);
        check("arst.w_gptr", 32'(bus.w_gptr), 26);
        check("arst.full", 32'(bus.full), 0);
`ifdef FIFO_WALMOST_FULL_EN
        check("arst.almost_full", 32'(bus.almost_full), 0);
`endif
        do_reset();
        repeat (5) step(1'b1, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-domain pointer and full-flag controller for the asynchronous FIFO. Sits directly upstream of the FIFO memory and drives its w_ptr and full inputs.
- Gray-encoded write pointer is published to the read domain; the read domain's Gray pointer is synchronized back in to generate full.
- Supports the non-power-of-two depth of 45 entries at memory addresses 9..53 by using a reflected Gray range, so every pointer step, including wrap, changes exactly one bit.

Parameters:
- DEPTH, 45, number of FIFO entries; 2*DEPTH <= 2**CNT_W required.
- ADDR_LO, 9, first memory address; last address = ADDR_LO+DEPTH-1 = 53.
- PTR_W, 6, memory address width.
- CNT_W, 7, width of the Gray pointer (wrap bit included).
- SYNC_STAGES, 2, flop stages on the incoming read Gray pointer, minimum 2.
- AF_LEVEL, 40, almost-full threshold; used only with the optional feature.

Ports:
- w_clk  in  1  write clock; only clock of the block.
- arstn  in  1  asynchronous active-low reset.
- w_en  in  1  write request; accepted when w_en && !full.
- r_gptr  in  CNT_W  read Gray pointer from the read domain; asynchronous to w_clk.
- w_ptr  out  PTR_W  memory write address.
- full  out  1  FIFO full, registered.
- w_gptr  out  CNT_W  write Gray pointer to the read domain, registered.
- almost_full  out  1  present only with FIFO_WALMOST_FULL_EN.

Behaviour:
- Internal sequence index s runs BASE..BASE+2*DEPTH-1, with BASE = 2**(CNT_W-1)-DEPTH (19..108 by default). It increments by 1 and wraps from the top back to BASE.
- w_gptr = s ^ (s>>1), registered. The range is mirror-symmetric about 2**(CNT_W-1), so the wrap from 108 to 19 flips only the MSB.
- Logical count c = s-BASE, range 0..89. w_ptr = ADDR_LO + (c mod DEPTH), registered with s.
- Accept = w_en && !full. On accept, s, w_ptr and w_gptr advance on the same w_clk edge that the memory captures data at the old w_ptr.
- Accept with full=1 is ignored: no pointer change and no error output.
- Read-pointer synchronizer: SYNC_STAGES flops on r_gptr. Last stage is Gray-decoded to binary, then rc = decoded-BASE.
- full_next = ((c_next - rc + 2*DEPTH) mod 2*DEPTH) == DEPTH, where c_next is the post-accept count. full is registered, so it asserts on the same edge as the 45th write and never permits an overwrite.
- Deassertion of full lags a read by SYNC_STAGES+1 w_clk edges in the worst case. This is conservative and correct.
- Occupancy arithmetic uses CNT_W+1 bits internally to avoid negative wrap.
- Reset (async assert, release synchronous to w_clk at system level):
  - s = BASE, w_ptr = ADDR_LO, w_gptr = gray(BASE) = 7'b0011010 for 19.
  - full = 0, almost_full = 0.
  - Every synchronizer flop resets to gray(BASE), the read side's reset value, so no false full is seen after reset.
- Reset mid-operation: all state returns immediately to reset values. In-flight writes are discarded, and the memory contents are cleared by its own reset.
- A corrupt r_gptr (more than one bit changing between samples) is out of contract; behaviour is undefined but must not hang. Pointer stepping continues.

Optional Feature:
- Macro: FIFO_WALMOST_FULL_EN.
- Defined:
  - almost_full port exists, registered.
  - almost_full = occupancy_next >= AF_LEVEL, computed with the same arithmetic and timing as full.
  - Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle -> w_ptr=9, full=0, w_gptr=gray(19); hold for 10 cycles with no change.
- 45 back-to-back writes, r_gptr held at gray(19) -> w_ptr steps 9..53 then returns to 9; full=1 on the 45th write edge.
- 46th write with full=1 -> w_ptr stays 9, w_gptr unchanged, full stays 1.
- Drive r_gptr to gray(20) while full -> full=0 within 3 cycles; the next write is accepted at address 9.
- 200 writes with the read side tracking -> every w_gptr transition, including 108->19, has Hamming distance 1.
- Assert arstn low after 30 writes -> all outputs return to reset values asynchronously.
- With FIFO_WALMOST_FULL_EN: 40 writes -> almost_full=1 and full=0; 45 writes -> both 1.
